// File: rtl/reg_scan_stats_if.sv
// Host-side bus of reg_scan_stats: scan control, load/inspect ports and scan results.
// The max result exists only when MAX_TRACK_EN is defined.
interface reg_scan_stats_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SUM_W  = 13
);
    logic              go;
    logic [ADDR_W:0]   len;
    logic [1:0]        mode;
    logic [DATA_W-1:0] sat_val;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] min;
    logic [SUM_W-1:0]  sum;
    logic [ADDR_W:0]   fix_cnt;
`ifdef MAX_TRACK_EN
    logic [DATA_W-1:0] max;
`endif

    modport master (
        output go, len, mode, sat_val, ld_en, ld_addr, ld_data, rd_addr,
        input  rd_data, busy, done, min, sum, fix_cnt
`ifdef MAX_TRACK_EN
        , input max
`endif
    );

    modport slave (
        input  go, len, mode, sat_val, ld_en, ld_addr, ld_data, rd_addr,
        output rd_data, busy, done, min, sum, fix_cnt
`ifdef MAX_TRACK_EN
        , output max
`endif
    );
endinterface

// File: rtl/reg_scan_stats.sv
// Scan-and-fix engine over a DEPTH x DATA_W register file: reports min/sum (and max with
// MAX_TRACK_EN defined) of the original values and conditionally rewrites entries by mode.
module reg_scan_stats #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SUM_W  = 13
) (
    input logic             Clk,
    input logic             Rst,
    reg_scan_stats_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EVAL = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] ONES_L  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO_L  = {DATA_W{1'b0}};

    state_t            state_r, state_nx_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]   len_r, idx_r, len_clamp_s, idx_inc_s;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] sat_r, temp_r, min_r, fix_val_s;
    logic [SUM_W-1:0]  sum_r;
    logic [ADDR_W:0]   fix_r;
    logic              busy_r, done_r;
    logic              start_s, load_s, read_s, eval_s, acc_s, fin_s, fix_wr_s;
    logic              ld_ok_s, rd_ok_s;

    assign len_clamp_s = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    assign idx_inc_s   = idx_r + ONE_L;
    assign ld_ok_s     = ({1'b0, bus.ld_addr} < DEPTH_L);
    assign rd_ok_s     = ({1'b0, bus.rd_addr} < DEPTH_L);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        load_s     = 1'b0;
        read_s     = 1'b0;
        eval_s     = 1'b0;
        acc_s      = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = bus.ld_en & ld_ok_s;
                if (bus.go) begin
                    start_s    = 1'b1;
                    state_nx_s = (len_clamp_s != {(ADDR_W+1){1'b0}}) ? ST_READ : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ: begin
                read_s     = 1'b1;
                state_nx_s = ST_EVAL;
            end
            ST_EVAL: begin
                eval_s     = 1'b1;
                state_nx_s = ST_ACC;
            end
            ST_ACC: begin
                acc_s = 1'b1;
                if (idx_inc_s == len_r) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_DONE: begin
                fin_s      = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Rewrite decision for the entry held in temp_r; modes 00 and 11 never rewrite.
    always_comb begin
        fix_wr_s  = 1'b0;
        fix_val_s = temp_r;
        case (mode_r)
            2'b01: begin
                if (temp_r[DATA_W-1]) begin
                    fix_wr_s  = 1'b1;
                    fix_val_s = {1'b0, temp_r[DATA_W-2:0]};
                end else begin
                    fix_wr_s  = 1'b0;
                end
            end
            2'b10: begin
                if (temp_r > sat_r) begin
                    fix_wr_s  = 1'b1;
                    fix_val_s = sat_r;
                end else begin
                    fix_wr_s  = 1'b0;
                end
            end
            default: begin
                fix_wr_s = 1'b0;
            end
        endcase
    end

    // Register file: host loads in IDLE, scan writebacks in EVAL (never the same cycle).
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= ZERO_L;
            end
        end else if (load_s) begin
            mem_r[bus.ld_addr] <= bus.ld_data;
        end else if (eval_s && fix_wr_s) begin
            mem_r[idx_r[ADDR_W-1:0]] <= fix_val_s;
        end
    end

    // Scan datapath: configuration latch, running statistics and handshake flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            len_r  <= {(ADDR_W+1){1'b0}};
            idx_r  <= {(ADDR_W+1){1'b0}};
            mode_r <= 2'b00;
            sat_r  <= ZERO_L;
            temp_r <= ZERO_L;
            min_r  <= ONES_L;
            sum_r  <= {SUM_W{1'b0}};
            fix_r  <= {(ADDR_W+1){1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (start_s) begin
                len_r  <= len_clamp_s;
                idx_r  <= {(ADDR_W+1){1'b0}};
                mode_r <= bus.mode;
                sat_r  <= bus.sat_val;
                min_r  <= ONES_L;
                sum_r  <= {SUM_W{1'b0}};
                fix_r  <= {(ADDR_W+1){1'b0}};
                busy_r <= 1'b1;
            end
            if (read_s) begin
                temp_r <= mem_r[idx_r[ADDR_W-1:0]];
            end
            if (eval_s) begin
                if (temp_r < min_r) begin
                    min_r <= temp_r;
                end
                if (fix_wr_s) begin
                    fix_r <= fix_r + ONE_L;
                end
            end
            // Sum always uses the value as read, never the rewritten one.
            if (acc_s) begin
                sum_r <= sum_r + SUM_W'(temp_r);
                idx_r <= idx_inc_s;
            end
            if (fin_s) begin
                busy_r <= 1'b0;
            end
            done_r <= fin_s;
        end
    end

`ifdef MAX_TRACK_EN
    logic [DATA_W-1:0] max_r;

    // Running maximum of original values, cleared on every accepted go.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            max_r <= ZERO_L;
        end else if (start_s) begin
            max_r <= ZERO_L;
        end else if (eval_s && (temp_r > max_r)) begin
            max_r <= temp_r;
        end
    end

    assign bus.max = max_r;
`endif

    assign bus.rd_data = rd_ok_s ? mem_r[bus.rd_addr] : ZERO_L;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.min     = min_r;
    assign bus.sum     = sum_r;
    assign bus.fix_cnt = fix_r;
endmodule

// File: tb/tb_reg_scan_stats.sv
// Self-checking bench for reg_scan_stats: directed scenarios plus randomized scans
// compared against an array-based reference model.
module tb_reg_scan_stats;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ref_mem [16];
    int   exp_min, exp_sum, exp_max, exp_fix, exp_lat;

    always #5 clk = ~clk;

    reg_scan_stats_if #(.DATA_W(8), .ADDR_W(4), .SUM_W(13)) bus ();

    reg_scan_stats #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .SUM_W(13)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "bench timeout");
    end

    function automatic void model_scan(input int ln, input int md, input int sv);
        int n;
        n = (ln > 16) ? 16 : ln;
        exp_min = 255; exp_sum = 0; exp_max = 0; exp_fix = 0;
        for (int k = 0; k < n; k++) begin
            int v;
            v = ref_mem[k];
            if (v < exp_min) exp_min = v;
            if (v > exp_max) exp_max = v;
            exp_sum = exp_sum + v;
            if (md == 1 && v >= 128) begin
                ref_mem[k] = v - 128; exp_fix++;
            end else if (md == 2 && v > sv) begin
                ref_mem[k] = sv; exp_fix++;
            end
        end
        exp_sum = exp_sum % 8192;
        exp_lat = 3 * n + 1;
    endfunction

    task automatic load_entry(input int a, input int d);
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = 4'(a); bus.ld_data = 8'(d);
        @(negedge clk);
        bus.ld_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Pulses go for one edge and waits for done; lat = edges after the go edge, -1 on timeout.
    task automatic launch(input int ln, input int md, input int sv, input bit ld_with,
                          input int la, input int ldv, input bit poke, output int lat);
        @(negedge clk);
        bus.go = 1'b1; bus.len = 5'(ln); bus.mode = 2'(md); bus.sat_val = 8'(sv);
        bus.ld_en = ld_with; bus.ld_addr = 4'(la); bus.ld_data = 8'(ldv);
        @(negedge clk);
        bus.go = 1'b0; bus.ld_en = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (poke && lat == 5) begin
                bus.go = 1'b1; bus.len = 5'd1; bus.ld_en = 1'b1;
                bus.ld_addr = 4'd0; bus.ld_data = 8'h11;
            end else begin
                bus.go = 1'b0; bus.ld_en = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.go = 1'b0; bus.ld_en = 1'b0;
        if (lat >= 200) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 5;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", bus.done); end
        if (bus.min !== 8'hFF) begin failures++; $display("FAIL reset_min got=%0h want=ff", bus.min); end
        if (bus.sum !== 13'd0) begin failures++; $display("FAIL reset_sum got=%0d want=0", bus.sum); end
        if (bus.fix_cnt !== 5'd0) begin failures++; $display("FAIL reset_fix got=%0d want=0", bus.fix_cnt); end
`ifdef MAX_TRACK_EN
        checks++;
        if (bus.max !== 8'h00) begin failures++; $display("FAIL reset_max got=%0h want=0", bus.max); end
`endif
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_mem[%0d] got=%0h want=0", k, bus.rd_data); end
            ref_mem[k] = 0;
        end
    endtask

    task automatic test_mode_clear_msb();
        int vec [16] = '{200, 5, 130, 7, 64, 33, 250, 18, 99, 128, 12, 77, 141, 60, 255, 9};
        int lat;
        for (int k = 0; k < 16; k++) load_entry(k, vec[k]);
        model_scan(16, 1, 0);
        launch(16, 1, 0, 1'b0, 0, 0, 1'b0, lat);
        checks += 5;
        if (lat !== exp_lat) begin failures++; $display("FAIL clr_latency got=%0d want=%0d", lat, exp_lat); end
        if (bus.min !== 8'(exp_min)) begin failures++; $display("FAIL clr_min got=%0d want=%0d", bus.min, exp_min); end
        if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL clr_sum got=%0d want=%0d", bus.sum, exp_sum); end
        if (bus.fix_cnt !== 5'(exp_fix)) begin failures++; $display("FAIL clr_fix got=%0d want=%0d", bus.fix_cnt, exp_fix); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL clr_busy_at_done got=%0b want=0", bus.busy); end
        @(negedge clk);
        checks += 3;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL clr_done_width got=%0b want=0", bus.done); end
        if (bus.min !== 8'(exp_min)) begin failures++; $display("FAIL clr_min_hold got=%0d want=%0d", bus.min, exp_min); end
        if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL clr_sum_hold got=%0d want=%0d", bus.sum, exp_sum); end
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'(ref_mem[k])) begin failures++; $display("FAIL clr_mem[%0d] got=%0d want=%0d", k, bus.rd_data, ref_mem[k]); end
        end
    endtask

    task automatic test_mode_saturate();
        int vec [16] = '{200, 5, 130, 7, 64, 33, 250, 18, 99, 128, 12, 77, 141, 60, 255, 9};
        int lat;
        for (int k = 0; k < 16; k++) load_entry(k, vec[k]);
        model_scan(4, 2, 100);
        launch(4, 2, 100, 1'b0, 0, 0, 1'b0, lat);
        checks += 4;
        if (lat !== exp_lat) begin failures++; $display("FAIL sat_latency got=%0d want=%0d", lat, exp_lat); end
        if (bus.min !== 8'(exp_min)) begin failures++; $display("FAIL sat_min got=%0d want=%0d", bus.min, exp_min); end
        if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL sat_sum got=%0d want=%0d", bus.sum, exp_sum); end
        if (bus.fix_cnt !== 5'(exp_fix)) begin failures++; $display("FAIL sat_fix got=%0d want=%0d", bus.fix_cnt, exp_fix); end
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'(ref_mem[k])) begin failures++; $display("FAIL sat_mem[%0d] got=%0d want=%0d", k, bus.rd_data, ref_mem[k]); end
        end
    endtask

    task automatic test_len_zero();
        int lat;
        model_scan(0, 1, 0);
        launch(0, 1, 0, 1'b0, 0, 0, 1'b0, lat);
        checks += 4;
        if (lat !== 1) begin failures++; $display("FAIL len0_latency got=%0d want=1", lat); end
        if (bus.min !== 8'hFF) begin failures++; $display("FAIL len0_min got=%0h want=ff", bus.min); end
        if (bus.sum !== 13'd0) begin failures++; $display("FAIL len0_sum got=%0d want=0", bus.sum); end
        if (bus.fix_cnt !== 5'd0) begin failures++; $display("FAIL len0_fix got=%0d want=0", bus.fix_cnt); end
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'(ref_mem[k])) begin failures++; $display("FAIL len0_mem[%0d] got=%0d want=%0d", k, bus.rd_data, ref_mem[k]); end
        end
    endtask

    task automatic test_len_clamp();
        int lat;
        for (int k = 0; k < 16; k++) load_entry(k, 255);
        model_scan(31, 0, 0);
        launch(31, 0, 0, 1'b0, 0, 0, 1'b0, lat);
        checks += 4;
        if (lat !== 49) begin failures++; $display("FAIL clamp_latency got=%0d want=49", lat); end
        if (bus.sum !== 13'd4080) begin failures++; $display("FAIL clamp_sum got=%0d want=4080", bus.sum); end
        if (bus.min !== 8'd255) begin failures++; $display("FAIL clamp_min got=%0d want=255", bus.min); end
        if (bus.fix_cnt !== 5'd0) begin failures++; $display("FAIL clamp_fix got=%0d want=0", bus.fix_cnt); end
    endtask

    task automatic test_load_with_go();
        int lat;
        for (int k = 0; k < 16; k++) load_entry(k, 20 + k);
        ref_mem[2] = 240;
        model_scan(4, 1, 0);
        launch(4, 1, 0, 1'b1, 2, 240, 1'b0, lat);
        checks += 3;
        if (lat !== exp_lat) begin failures++; $display("FAIL ldgo_latency got=%0d want=%0d", lat, exp_lat); end
        if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL ldgo_sum got=%0d want=%0d", bus.sum, exp_sum); end
        if (bus.fix_cnt !== 5'(exp_fix)) begin failures++; $display("FAIL ldgo_fix got=%0d want=%0d", bus.fix_cnt, exp_fix); end
        bus.rd_addr = 4'd2; #1;
        checks++;
        if (bus.rd_data !== 8'(ref_mem[2])) begin failures++; $display("FAIL ldgo_mem2 got=%0d want=%0d", bus.rd_data, ref_mem[2]); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        for (int k = 0; k < 16; k++) load_entry(k, (k * 37 + 90) % 256);
        model_scan(16, 1, 0);
        launch(16, 1, 0, 1'b0, 0, 0, 1'b1, lat);
        checks += 3;
        if (lat !== exp_lat) begin failures++; $display("FAIL busy_latency got=%0d want=%0d", lat, exp_lat); end
        if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL busy_sum got=%0d want=%0d", bus.sum, exp_sum); end
        if (bus.fix_cnt !== 5'(exp_fix)) begin failures++; $display("FAIL busy_fix got=%0d want=%0d", bus.fix_cnt, exp_fix); end
        @(negedge clk);
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after got=%0b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL busy_done_width got=%0b want=0", bus.done); end
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'(ref_mem[k])) begin failures++; $display("FAIL busy_mem[%0d] got=%0d want=%0d", k, bus.rd_data, ref_mem[k]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int ln, md, sv, lat;
            for (int k = 0; k < 16; k++) load_entry(k, int'($urandom_range(0, 255)));
            ln = int'($urandom_range(0, 31));
            md = int'($urandom_range(0, 3));
            sv = int'($urandom_range(0, 255));
            model_scan(ln, md, sv);
            launch(ln, md, sv, 1'b0, 0, 0, 1'b0, lat);
            checks += 4;
            if (lat !== exp_lat) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, lat, exp_lat); end
            if (bus.min !== 8'(exp_min)) begin failures++; $display("FAIL rnd%0d_min got=%0d want=%0d", it, bus.min, exp_min); end
            if (bus.sum !== 13'(exp_sum)) begin failures++; $display("FAIL rnd%0d_sum got=%0d want=%0d", it, bus.sum, exp_sum); end
            if (bus.fix_cnt !== 5'(exp_fix)) begin failures++; $display("FAIL rnd%0d_fix got=%0d want=%0d", it, bus.fix_cnt, exp_fix); end
`ifdef MAX_TRACK_EN
            checks++;
            if (bus.max !== 8'(exp_max)) begin failures++; $display("FAIL rnd%0d_max got=%0d want=%0d", it, bus.max, exp_max); end
`endif
            for (int k = 0; k < 16; k++) begin
                bus.rd_addr = 4'(k); #1;
                checks++;
                if (bus.rd_data !== 8'(ref_mem[k])) begin failures++; $display("FAIL rnd%0d_mem[%0d] got=%0d want=%0d", it, k, bus.rd_data, ref_mem[k]); end
            end
        end
    endtask

`ifdef MAX_TRACK_EN
    task automatic test_max();
        int lat;
        load_entry(0, 3); load_entry(1, 250); load_entry(2, 7);
        for (int k = 3; k < 16; k++) load_entry(k, int'($urandom_range(0, 249)));
        launch(16, 0, 0, 1'b0, 0, 0, 1'b0, lat);
        checks++;
        if (bus.max !== 8'd250) begin failures++; $display("FAIL max_track got=%0d want=250", bus.max); end
    endtask
`endif

    task automatic test_reset_mid_scan();
        int seen;
        for (int k = 0; k < 16; k++) load_entry(k, 200 + k);
        @(negedge clk);
        bus.go = 1'b1; bus.len = 5'd16; bus.mode = 2'b01; bus.sat_val = 8'd0;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checks += 5;
        if (seen !== 0) begin failures++; $display("FAIL rstmid_done got=%0d pulses want=0", seen); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b want=0", bus.busy); end
        if (bus.min !== 8'hFF) begin failures++; $display("FAIL rstmid_min got=%0h want=ff", bus.min); end
        if (bus.sum !== 13'd0) begin failures++; $display("FAIL rstmid_sum got=%0d want=0", bus.sum); end
        if (bus.fix_cnt !== 5'd0) begin failures++; $display("FAIL rstmid_fix got=%0d want=0", bus.fix_cnt); end
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k); #1;
            checks++;
            if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL rstmid_mem[%0d] got=%0h want=0", k, bus.rd_data); end
            ref_mem[k] = 0;
        end
    endtask

    initial begin
        bus.go = 1'b0; bus.len = 5'd0; bus.mode = 2'b00; bus.sat_val = 8'd0;
        bus.ld_en = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 8'd0; bus.rd_addr = 4'd0;
        test_reset();
        test_mode_clear_msb();
        test_mode_saturate();
        test_len_zero();
        test_len_clamp();
        test_load_with_go();
        test_busy_ignore();
        test_random();
`ifdef MAX_TRACK_EN
        test_max();
`endif
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
